// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host byte transmitter: 11-bit frame, device drives clock.
// Optional PS2_DEV_TX_RETRY_EN: after host inhibit, resend the latched byte once the bus idles.
module ps2_dev_tx #(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_abort
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(CLK_DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_bit_idx;
    logic [10:0] r_frame;

    logic        w_cnt_done;
    logic        w_last_bit;
    logic [3:0]  w_next_idx;

    assign w_cnt_done = (r_cnt == LP_CNT_LAST);
    assign w_last_bit = (r_bit_idx == 4'd10);
    assign w_next_idx = r_bit_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_frame     <= '0;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_abort    <= 1'b0;
        end else begin
            tx_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // Frame is {stop, odd parity, data LSB-first, start}
                        r_frame   <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        r_bit_idx <= '0;
                        r_cnt     <= '0;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_WAIT_BUS;
                    end
                end

                ST_WAIT_BUS: begin
                    if (ps2_clk_i && ps2_data_i) begin
                        if (w_cnt_done) begin
                            r_cnt       <= '0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= ~r_frame[r_bit_idx];
                            r_state     <= ST_HIGH;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end

                ST_HIGH: begin
                    if (!ps2_clk_i && !w_last_bit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_abort    <= 1'b1;
                        r_cnt       <= '0;
                        r_bit_idx   <= '0;
`ifdef PS2_DEV_TX_RETRY_EN
                        r_state     <= ST_WAIT_BUS;
`else
                        busy        <= 1'b0;
                        tx_ready    <= 1'b1;
                        r_state     <= ST_IDLE;
`endif
                    end else if (w_cnt_done) begin
                        r_cnt      <= '0;
                        ps2_clk_oe <= 1'b1;
                        r_state    <= ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_LOW: begin
                    if (w_cnt_done) begin
                        r_cnt <= '0;
                        if (w_last_bit) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            busy        <= 1'b0;
                            tx_ready    <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_bit_idx   <= w_next_idx;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= ~r_frame[w_next_idx];
                            r_state     <= ST_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx at CLK_DIV=4; host modelled as open-drain wired-AND lines.
// Honours PS2_DEV_TX_RETRY_EN for the inhibit scenario.
module tb_ps2_dev_tx;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_abort;

    logic       host_clk  = 1'b1;
    logic       host_data = 1'b1;

    int n_total = 0;
    int n_bad   = 0;
    int n_abort = 0;

    assign ps2_clk_i  = ~ps2_clk_oe & host_clk;
    assign ps2_data_i = ~ps2_data_oe & host_data;

    ps2_dev_tx #(.CLK_DIV(CLK_DIV)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_abort   (tx_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_abort) n_abort++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer a byte and return at the first negedge showing busy.
    task automatic accept(input logic [7:0] b, input logic keep_valid);
        int k;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 100);
        check("accept", {31'd0, busy}, 32'd1);
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        while (!ps2_data_oe && waited < 200) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Called on the first HIGH cycle; returns at the first negedge with busy low.
    task automatic capture_frame(output logic [10:0] bits, output int len, output int npulse,
                                 output int bad_pulse, output int ready_viol);
        logic prev;
        int   cur;
        bits = '0; len = 0; npulse = 0; bad_pulse = 0; ready_viol = 0;
        prev = 1'b0; cur = 0;
        while (busy && len < 400) begin
            len++;
            if (tx_ready) ready_viol++;
            if (ps2_clk_oe) begin
                if (!prev) begin
                    if (npulse < 11) bits[npulse] = ps2_data_i;
                    npulse++;
                    cur = 0;
                end
                cur++;
            end else if (prev && cur != CLK_DIV) begin
                bad_pulse++;
            end
            prev = ps2_clk_oe;
            @(negedge clk);
        end
        if (prev && cur != CLK_DIV) bad_pulse++;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic par);
        logic [10:0] bits;
        logic [10:0] exp;
        int len, npulse, bad_pulse, ready_viol;
        exp = {1'b1, par, b, 1'b0};
        capture_frame(bits, len, npulse, bad_pulse, ready_viol);
        check({tag, "_bits"},   {21'd0, bits}, {21'd0, exp});
        check({tag, "_len"},    len, 22 * CLK_DIV);
        check({tag, "_pulses"}, npulse, 11);
        check({tag, "_pwidth"}, bad_pulse, 0);
        check({tag, "_rdy_in"}, ready_viol, 0);
        check({tag, "_rdy_end"}, {31'd0, tx_ready}, 32'd1);
        check({tag, "_oe_end"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input logic par);
        int w;
        accept(b, 1'b0);
        wait_start(w);
        check({tag, "_start"}, w, CLK_DIV);
        check_frame(tag, b, par);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k, cnt, ab0;
        logic prev;

        rst = 1'b1; tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {27'd0, tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_abort}, 32'b10000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0x1C: data bits 0,0,1,1,1,0,0,0 -> three ones, parity 0
        send_and_check("b1C", 8'h1C, 1'b0);
        send_and_check("bFF", 8'hFF, 1'b1);
        send_and_check("b00", 8'h00, 1'b1);
        send_and_check("b01", 8'h01, 1'b0);

        // Host holds clock low until well after accept
        host_clk = 1'b0;
        accept(8'h1C, 1'b0);
        cnt = 0;
        repeat (18) begin
            @(negedge clk);
            if (ps2_data_oe || ps2_clk_oe) cnt++;
        end
        check("inh_hold", cnt, 0);
        host_clk = 1'b1;
        wait_start(w);
        check("inh_release", w, CLK_DIV);
        check_frame("inh", 8'h1C, 1'b0);

        // Host inhibit in HIGH phase of frame bit 3 (data bit 2 of 0x00 -> data pulled low)
        ab0 = n_abort;
        accept(8'h00, 1'b0);
        wait_start(w);
        k = 0; cnt = 0;
        while (cnt < 3 && k < 200) begin
            prev = ps2_clk_oe;
            @(negedge clk);
            k++;
            if (prev && !ps2_clk_oe) cnt++;
        end
        check("ab_pre_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
        host_clk = 1'b0;
        @(negedge clk);
        host_clk = 1'b1;
        check("ab_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("ab_pulse", {31'd0, tx_abort}, 32'd1);
`ifdef PS2_DEV_TX_RETRY_EN
        check("ab_busy", {30'd0, busy, tx_ready}, 32'b10);
        @(negedge clk);
        check("ab_pulse_end", {31'd0, tx_abort}, 32'd0);
        wait_start(w);
        check("ab_retry_start", w, CLK_DIV - 1);
        check_frame("ab_retry", 8'h00, 1'b1);
`else
        check("ab_idle", {30'd0, busy, tx_ready}, 32'b01);
        @(negedge clk);
        check("ab_pulse_end", {31'd0, tx_abort}, 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || ps2_clk_oe || ps2_data_oe) cnt++;
        end
        check("ab_stay_idle", cnt, 0);
`endif
        check("ab_count", n_abort - ab0, 1);

        // Reset during LOW phase of bit 6
        ab0 = n_abort;
        accept(8'h1C, 1'b0);
        wait_start(w);
        k = 0; cnt = 0;
        while (cnt < 7 && k < 300) begin
            prev = ps2_clk_oe;
            @(negedge clk);
            k++;
            if (!prev && ps2_clk_oe) cnt++;
        end
        check("rst6_in_low", {31'd0, ps2_clk_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst6_outs", {27'd0, tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_abort}, 32'b10000);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || ps2_clk_oe || ps2_data_oe) cnt++;
        end
        check("rst6_quiet", cnt, 0);
        check("rst6_no_abort", n_abort - ab0, 0);

        // Back-to-back with tx_valid held; tx_data changes right after the first accept
        accept(8'hA5, 1'b1);
        tx_data = 8'h5A;
        wait_start(w);
        check("b2b1_start", w, CLK_DIV);
        check_frame("b2b1", 8'hA5, 1'b1);
        @(negedge clk);
        check("b2b2_accept", {31'd0, busy}, 32'd1);
        tx_valid = 1'b0;
        wait_start(w);
        check("b2b2_start", w, CLK_DIV);
        check_frame("b2b2", 8'h5A, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 1000, giving PS/2 clock half-period in clk cycles (legal range 2..65535).
REQ-002 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port tx_data  input  8  byte to send to host.
REQ-005 SHALL provide port tx_valid  input  1  tx_data valid.
REQ-006 SHALL provide port tx_ready  output  1  byte accepted when tx_valid and tx_ready are both high on a clk edge.
REQ-007 SHALL provide port ps2_clk_i  input  1  sampled PS2_CLK line level.
REQ-008 SHALL provide port ps2_data_i  input  1  sampled PS2_DATA line level.
REQ-009 SHALL provide port ps2_clk_oe  output  1  1 = pull PS2_CLK low (open-drain); 0 = release.
REQ-010 SHALL provide port ps2_data_oe  output  1  1 = pull PS2_DATA low; 0 = release.
REQ-011 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-012 SHALL provide port tx_abort  output  1  one-cycle pulse when a frame is cut by host inhibit.

Function
REQ-013 SHALL implement states IDLE, WAIT_BUS, HIGH, LOW.
REQ-014 IDLE: tx_ready=1; on accept, latch tx_data, compute odd parity, set bit index 0, go WAIT_BUS.
REQ-015 WAIT_BUS: both oe=0; count consecutive cycles with ps2_clk_i=1 and ps2_data_i=1; on reaching CLK_DIV go HIGH; any low sample clears the count.
REQ-016 Frame SHALL be 11 bits: start 0, data bits 0..7 LSB first, odd parity (total ones in data+parity odd), stop 1.
REQ-017 HIGH: ps2_clk_oe=0; ps2_data_oe = inverse of current bit from first HIGH cycle; duration CLK_DIV cycles, then LOW.
REQ-018 LOW: ps2_clk_oe=1, ps2_data_oe held; duration CLK_DIV cycles; then increment bit index and go HIGH, or after bit 10 release both lines and go IDLE.
REQ-019 Each bit SHALL take exactly 2*CLK_DIV cycles; frame exactly 22*CLK_DIV cycles from first HIGH cycle to IDLE.
REQ-020 Host inhibit: ps2_clk_i sampled 0 in any HIGH cycle of bits 0..9 SHALL abort; stop-bit HIGH phase ignores ps2_clk_i.
REQ-021 On abort, both oe SHALL be 0 from the next cycle and tx_abort SHALL pulse exactly once.
REQ-022 Data and parity computation SHALL use the latched byte; tx_data changes after accept have no effect.
REQ-023 tx_ready SHALL be 0 outside IDLE; tx_valid outside IDLE ignored.
REQ-024 Phase counter SHALL count 0..CLK_DIV-1 and wrap, never overflow; width sized for 65535.

Reset
REQ-025 rst SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_abort=0, tx_ready=1 on next edge.
REQ-026 rst mid-frame SHALL release both lines on next edge and discard the latched byte without tx_abort.

Configuration
REQ-027 Macro PS2_DEV_TX_RETRY_EN SHALL select abort behaviour.
REQ-028 With PS2_DEV_TX_RETRY_EN defined: after abort, go WAIT_BUS, keep latched byte, restart from start bit once bus idle for CLK_DIV cycles.
REQ-029 Without it: after abort, go IDLE, drop byte.

Verification (CLK_DIV=4)
REQ-030 Send 0x1C, host idle -> data line 0,0,0,1,1,1,0,0,0,0(parity),1; 11 clock-low pulses of 4 cycles; frame 88 cycles; busy falls after.
REQ-031 Send 0xFF -> parity bit 1; send 0x00 -> parity bit 1; 0x01 -> parity 0.
REQ-032 Hold ps2_clk_i low before accept, release at cycle 20 -> first HIGH starts exactly 4 cycles after release.
REQ-033 Force ps2_clk_i=0 during HIGH of bit 3 -> oe both 0 next cycle, tx_abort one pulse; RETRY_EN: full frame resent after idle; else IDLE, tx_ready=1.
REQ-034 Assert rst during LOW of bit 6 -> next edge both oe 0, busy 0, tx_ready 1, no tx_abort.
REQ-035 Back-to-back tx_valid with 0xA5,0x5A -> second accepted only in IDLE after first stop bit; both frames correct.
